// File: rtl/fp_pkg.sv
`default_nettype none
// ==========================================================================
// fp_pkg -- shared binary32 field widths, constants and types (Rev 1.0)
// ==========================================================================
package fp_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int SIG_W   = MANT_W + 4;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ==========================================================================
// fp_lzc -- combinational 27-bit leading-zero counter (27 for all-zero) (Rev 1.0)
// ==========================================================================
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] value,
  output logic [4:0]       count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < SIG_W; i++) begin
      if (value[i]) count = 5'(SIG_W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_adder_subtractor.sv
`default_nettype none
// ==========================================================================
// float_adder_subtractor -- 6-state binary32 add/sub; FP_RNE_EN selects RNE over truncation
// Rev 1.0
// ==========================================================================
module float_adder_subtractor
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        op,
  input  logic        load,
  output logic [31:0] out,
  output logic        valid
);

`ifdef FP_RNE_EN
  localparam logic RNE_ON = 1'b1;
`else
  localparam logic RNE_ON = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             load_q, load_d, armed_q, armed_d, op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d, sub_q, sub_d, spec_q, spec_d, zero_q, zero_d;
  logic [31:0]      spec_val_q, spec_val_d, res_q, res_d, out_q, out_d;
  logic [9:0]       exp_q, exp_d;
  logic [SIG_W-1:0] big_q, big_d, small_q, small_d, norm_q, norm_d;
  logic [SIG_W:0]   sum_q, sum_d;
  logic             valid_q, valid_d;
  logic             accept;

  fp_t              fa, fb;
  logic             sb_eff, a_ge, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [4:0]       shamt, lz;
  logic [SIG_W-1:0] small_sig, lost;
  logic             rnd_up;
  logic [24:0]      mant_r;
  logic [9:0]       exp_r;
  logic [31:0]      ovf_val;

  assign fa       = fp_t'(a_q);
  assign fb       = fp_t'(b_q);
  assign sb_eff   = fb.sign ^ op_q;
  assign a_ge     = a_q[30:0] >= b_q[30:0];
  assign a_nan    = (fa.exp == 8'hFF) && (fa.mant != '0);
  assign b_nan    = (fb.exp == 8'hFF) && (fb.mant != '0);
  assign a_inf    = (fa.exp == 8'hFF) && (fa.mant == '0);
  assign b_inf    = (fb.exp == 8'hFF) && (fb.mant == '0);
  assign a_zero   = (fa.exp == '0);
  assign b_zero   = (fb.exp == '0);

  assign big_exp   = a_ge ? fa.exp : fb.exp;
  assign small_exp = a_ge ? fb.exp : fa.exp;
  assign exp_diff  = big_exp - small_exp;
  assign shamt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
  assign small_sig = {1'b1, (a_ge ? fb.mant : fa.mant), 3'b000};
  // Bits pushed below the sticky position collapse into the sticky lsb.
  assign lost      = small_sig & ~({SIG_W{1'b1}} << shamt);

  fp_lzc u_lzc (
    .value (sum_q[SIG_W-1:0]),
    .count (lz)
  );

  assign rnd_up  = RNE_ON & norm_q[2] & (norm_q[3] | norm_q[1] | norm_q[0]);
  assign mant_r  = {1'b0, norm_q[SIG_W-1:3]} + {24'b0, rnd_up};
  assign exp_r   = exp_q + {9'b0, mant_r[24]};
  assign ovf_val = RNE_ON ? {sign_q, POS_INF[30:0]} : {sign_q, 31'h7F7F_FFFF};

  always_comb begin
    state_d    = state_q;
    load_d     = load;
    armed_d    = armed_q | ~load;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    exp_d      = exp_q;
    big_d      = big_q;
    small_d    = small_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    zero_d     = zero_q;
    res_d      = res_q;
    out_d      = out_q;
    valid_d    = valid_q;
    accept     = load & ~load_q & armed_q & ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      ALIGN: begin
        sign_d     = a_ge ? fa.sign : sb_eff;
        sub_d      = fa.sign ^ sb_eff;
        exp_d      = {2'b00, big_exp};
        big_d      = {1'b1, (a_ge ? fa.mant : fb.mant), 3'b000};
        small_d    = (small_sig >> shamt) | {{(SIG_W-1){1'b0}}, |lost};
        spec_d     = 1'b1;
        spec_val_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != sb_eff))) spec_val_d = QNAN;
        else if (a_inf)              spec_val_d = fa.sign ? NEG_INF : POS_INF;
        else if (b_inf)              spec_val_d = sb_eff ? NEG_INF : POS_INF;
        else if (a_zero && b_zero)   spec_val_d = {fa.sign & sb_eff, 31'b0};
        else if (a_zero)             spec_val_d = {sb_eff, b_q[30:0]};
        else if (b_zero)             spec_val_d = a_q;
        else                         spec_d     = 1'b0;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = NORM;
      end
      NORM: begin
        zero_d = (sum_q == '0);
        if (sum_q[SIG_W]) begin
          norm_d = {sum_q[SIG_W:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + 10'd1;
        end else begin
          norm_d = sum_q[SIG_W-1:0] << lz;
          exp_d  = exp_q - {5'b0, lz};
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (spec_q)                          res_d = spec_val_q;
        else if (zero_q)                     res_d = '0;
        else if (exp_r[9] || exp_r == '0)    res_d = {sign_q, 31'b0};
        else if (exp_r >= 10'(EXP_MAX))      res_d = ovf_val;
        else res_d = {sign_q, exp_r[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
        state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        out_d   = res_q;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = ALIGN;
      a_d     = inA;
      b_d     = inB;
      op_d    = op;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      armed_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      zero_q     <= 1'b0;
      res_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      armed_q    <= armed_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      exp_q      <= exp_d;
      big_q      <= big_d;
      small_q    <= small_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      zero_q     <= zero_d;
      res_q      <= res_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_float_adder_subtractor.sv
`default_nettype none
// ==========================================================================
// tb_float_adder_subtractor -- directed table, random vs. exact-integer model, control corners
// Rev 1.0
// ==========================================================================
module tb_float_adder_subtractor;

`ifdef FP_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, op, load, valid;
  logic [31:0] inA, inB, out;
  int          n_vec = 0;
  int          n_mis = 0;

  float_adder_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inA   (inA),
    .inB   (inB),
    .op    (op),
    .load  (load),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Exact result as a wide integer scaled by 2^(emin-150), then rounded once.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic o);
    logic         sa, sb, rs;
    int           ea, eb, emin, p, e, sh;
    logic [299:0] va, vb, mag, m, rem, half;
    sa = a[31];
    sb = b[31] ^ o;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
    if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC0_0000 : {sa, 31'h7F80_0000};
    if (ea == 255) return {sa, 31'h7F80_0000};
    if (eb == 255) return {sb, 31'h7F80_0000};
    if (ea == 0 && eb == 0) return {sa & sb, 31'h0};
    if (ea == 0) return {sb, b[30:0]};
    if (eb == 0) return a;
    emin = (ea < eb) ? ea : eb;
    va = 300'({1'b1, a[22:0]}) << (ea - emin);
    vb = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (va >= vb) begin
      rs  = sa;
      mag = (sa == sb) ? va + vb : va - vb;
    end else begin
      rs  = sb;
      mag = (sa == sb) ? va + vb : vb - va;
    end
    if (mag == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (p > 23) begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = 300'd1 << (sh - 1);
      if (RNE && (rem > half || (rem == half && m[0]))) m = m + 300'd1;
    end else begin
      m = mag << (23 - p);
    end
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e <= 0) return {rs, 31'h0};
    if (e >= 255) return RNE ? {rs, 31'h7F80_0000} : {rs, 31'h7F7F_FFFF};
    return {rs, 8'(e), m[22:0]};
  endfunction

  // One accepted operation: clr = valid just after the accepting edge, lat = edge count to valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        output logic [31:0] res, output int lat, output logic clr);
    @(negedge clk);
    inA = a; inB = b; op = o; load = 1'b1;
    @(posedge clk); #1;
    clr = valid;
    @(negedge clk);
    load = 1'b0; inA = $urandom; inB = $urandom; op = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (valid) lat = k;
    end
    res = out;
  endtask

  initial begin
    logic [31:0] res, a, b, e;
    logic        clr, o, pv;
    int          lat, cnt;

    vecs[0]  = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000};
    vecs[1]  = '{32'h4146_6666, 32'h40E6_6666, 1'b1, 32'h40A6_6666};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h40E6_6666, 1'b1, 32'h7FC0_0000};
    vecs[3]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000};
    vecs[4]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000};
    vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, RNE ? 32'h7F80_0000 : 32'h7F7F_FFFF};
    vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
    vecs[7]  = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000};
    vecs[8]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000};
    vecs[9]  = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000};
    vecs[10] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000};
    vecs[11] = '{32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000};
    vecs[12] = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, RNE ? 32'h3F80_0001 : 32'h3F80_0000};
    vecs[13] = '{32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, RNE ? 32'hFF80_0000 : 32'hFF7F_FFFF};
    vecs[14] = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000};

    rst_n = 1'b0; load = 1'b0; op = 1'b0; inA = '0; inB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].o, res, lat, clr);
      check($sformatf("vec%0d_out", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("vec%0d_valid_clear", i), {31'b0, clr}, 32'h0);
    end

    // load held high across the whole operation and into DONE
    @(negedge clk);
    inA = 32'h4000_0000; inB = 32'h3F80_0000; op = 1'b0; load = 1'b1;
    pv = valid; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (valid && !pv) cnt++;
      pv = valid;
      if (k == 7) load = 1'b0;
    end
    check("hold_rises", 32'(cnt), 32'd1);
    check("hold_valid", {31'b0, valid}, 32'h1);
    check("hold_out", out, 32'h4040_0000);

    // extra load pulses while busy must be ignored
    @(negedge clk);
    inA = 32'h3FC0_0000; inB = 32'h4000_0000; op = 1'b1; load = 1'b1;
    lat = 0;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k > 0 && valid && lat == 0) lat = k;
      if (k == 0) begin load = 1'b0; inA = 32'h4120_0000; inB = 32'h3F80_0000; op = 1'b0; end
      if (k == 1 || k == 3) load = 1'b1;
      if (k == 2 || k == 4) load = 1'b0;
    end
    check("busy_latency", 32'(lat), 32'd5);
    check("busy_out", out, 32'hBF00_0000);
    check("busy_valid_held", {31'b0, valid}, 32'h1);

    // reset in ADD with load held high through and after reset
    @(negedge clk);
    inA = 32'h4040_0000; inB = 32'h3F80_0000; op = 1'b0; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; load = 1'b1;
    #1;
    check("abort_valid", {31'b0, valid}, 32'h0);
    check("abort_out", out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
    check("abort_no_valid", 32'(cnt), 32'd0);
    @(negedge clk);
    load = 1'b0;
    run_op(32'h3F80_0000, 32'h4000_0000, 1'b1, res, lat, clr);
    check("after_abort_out", res, 32'hBF80_0000);
    check("after_abort_latency", 32'(lat), 32'd5);

    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      b = $urandom;
      o = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b[30:23] = a[30:23];
        1: b[30:23] = a[30:23] + 8'($urandom_range(0, 3));
        2: b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
        default: ;
      endcase
      e = model(a, b, o);
      run_op(a, b, o, res, lat, clr);
      check($sformatf("rand%0d_out %08h%s%08h", i, a, o ? "-" : "+", b), res, e);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("rand%0d_valid_clear", i), {31'b0, clr}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_adder_subtractor.md
FLOAT_ADDER_SUBTRACTOR -- requirements
Module: float_adder_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; there are no parameters.
REQ-002 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port inA, input, 32 bits: IEEE-754 binary32 operand A.
REQ-005 Port inB, input, 32 bits: IEEE-754 binary32 operand B.
REQ-006 Port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-007 Port load, input, 1 bit: start request; level input, edge-detected internally.
REQ-008 Port out, output, 32 bits: binary32 result.
REQ-009 Port valid, output, 1 bit: out holds the result of the most recently accepted operation.

Function
REQ-010 The block SHALL accept an operation only on a load rising edge, i.e. load=1 sampled while the previous sample was 0; holding load high SHALL NOT restart the operation.
REQ-011 On acceptance the block SHALL capture inA, inB and op into internal registers; later input changes SHALL NOT affect that operation.
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND, DONE, advancing one state per cycle; the acceptance edge moves IDLE or DONE to ALIGN.
REQ-013 Latency SHALL be fixed: valid rises on the 5th rising clk edge after the accepting edge.
REQ-014 valid and out SHALL hold in DONE until the next accepted load; valid SHALL clear on that accepting edge.
REQ-015 A load rising edge in ALIGN..ROUND SHALL be ignored.
REQ-016 ALIGN SHALL do the following: unpack, restore the hidden 1, compute the effective sign of B (sign XOR op), and right-shift the smaller-exponent significand by the exponent difference, saturated at 26, keeping guard, round and sticky bits.
REQ-017 ADD SHALL add significands on equal effective signs, otherwise subtract the smaller magnitude from the larger; the result sign SHALL be the sign of the larger magnitude.
REQ-018 NORM SHALL do the following: shift right by 1 on carry-out, otherwise left by the leading-zero count, and adjust the exponent accordingly.
REQ-019 ROUND SHALL apply round-to-nearest-even when FP_RNE_EN is defined, and SHALL re-normalize on mantissa overflow.
REQ-020 An exact zero result SHALL be +0 (0x00000000), except (-0)+(-0), which SHALL give 0x80000000.
REQ-021 Any NaN input, or inf-inf with effective subtraction, SHALL give 0x7FC00000.
REQ-022 An infinite input otherwise SHALL give the correctly signed infinity.
REQ-023 Exponent overflow SHALL give a signed infinity (0x7F800000 / 0xFF800000).
REQ-024 Subnormal inputs SHALL be treated as signed zero; results below the minimum normal SHALL flush to signed zero.
REQ-025 NaN, infinity and zero special cases SHALL be resolved in ALIGN and carried through to keep the fixed latency.

Reset
REQ-026 While rst_n=0, regardless of clk: FSM=IDLE, valid=0, out=0x00000000, load-edge register=0, operand registers=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no valid pulse.
REQ-028 After deassertion, a load already high SHALL NOT count as a rising edge until it has been sampled low.

Configuration
REQ-029 With macro FP_RNE_EN defined, rounding SHALL be round-to-nearest-even using guard/round/sticky.
REQ-030 Without FP_RNE_EN, rounding SHALL truncate toward zero; overflow SHALL then give 0x7F7FFFFF / 0xFF7FFFFF instead of infinity; all other behaviour and the latency SHALL be unchanged.

Structure
REQ-031 Shared package fp_pkg SHALL hold: field widths (1/8/23), BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF, NEG_INF, the FSM state enum typedef, and an unpacked-float struct typedef {sign, exp, mant}.
REQ-032 There SHALL be one sub-module, fp_lzc: a combinational 27-bit leading-zero counter used by NORM.

Verification
REQ-033 op=0, inA=0x3FC00000 (1.5), inB=0x3FC00000 -> valid 5 cycles after the load edge, out=0x40400000 (3.0).
REQ-034 op=1, inA=0x41466666 (12.4), inB=0x40E66666 (7.2) -> out=0x40A66666 (5.2).
REQ-035 op=1, inA=0xFFFFFFFF (NaN), inB=0x40E66666 -> out=0x7FC00000; op=1, inA=inB=0x7F800000 -> out=0x7FC00000.
REQ-036 op=1, inA=inB=0x3F800000 -> out=0x00000000; op=0, inA=inB=0x7F7FFFFF -> out=0x7F800000 with FP_RNE_EN, 0x7F7FFFFF without.
REQ-037 Hold load high 4 cycles -> exactly one valid rising edge; a load pulse during ALIGN..ROUND is ignored; valid clears on the next accepted edge.
REQ-038 rst_n pulsed low in ADD -> valid stays 0, out=0x00000000, FSM returns to IDLE; the next load edge gives a correct result.
